// File: rtl/parity_frame_tx.sv
// parity_frame_tx
//   Serial framing transmitter: accepts a nibble plus its upstream parity bit
//   over valid/ready and shifts out start(0), d[0..3], parity, stop(1).
//   Every bit lasts CLKS_PER_BIT clocks. tx comes straight from a flop.
//
//   Build option: define PARITY_FRAME_TX_STOP2_EN for two stop bits.
//
// Ports
//   clk, rst_n   : rising-edge clock, async active-low reset
//   d, par_in    : nibble and its parity, sampled on valid && ready
//   valid, ready : input handshake; ready is high only in IDLE
//   tx           : serial line, idles high
//   busy         : frame in flight
//   done         : one-cycle pulse in the first IDLE cycle after STOP
module parity_frame_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  input  logic       par_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  typedef struct packed {
    logic       par;
    logic [3:0] d;
  } frame_t;

  state_t          state, state_nxt;
  frame_t          hold_q, hold_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      idx, idx_nxt;   // data index in DATA, stop-bit index in STOP
  logic            tx_q, tx_nxt;
  logic            done_q, done_nxt;
  logic            bit_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      hold_q <= '0;
      cnt    <= '0;
      idx    <= '0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      hold_q <= hold_nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      tx_q   <= tx_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_q;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    done_nxt  = 1'b0;
    tx_nxt    = 1'b1;
    bit_end   = (cnt == CNT_LAST);

    // bit-period counter free-runs while a frame is in flight
    if (state != IDLE) cnt_nxt = bit_end ? '0 : cnt + CW'(1);

    case (state)
      IDLE: begin
        if (valid) begin
          hold_nxt  = '{par: par_in, d: d};
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = START;
        end
      end
      START: if (bit_end) state_nxt = DATA;
      DATA: begin
        if (bit_end) begin
          if (idx == 2'd3) begin
            idx_nxt   = '0;
            state_nxt = PARITY;
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          idx_nxt   = '0;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
`ifdef PARITY_FRAME_TX_STOP2_EN
          if (idx == 2'd1) begin
            idx_nxt   = '0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            idx_nxt = 2'd1;
          end
`else
          done_nxt  = 1'b1;
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase

    // tx is registered: compute the level for the state being entered so the
    // line drops in the cycle right after the accept edge.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = hold_nxt.d[idx_nxt];
      PARITY:  tx_nxt = hold_nxt.par;
      default: tx_nxt = 1'b1;
    endcase
  end

  assign tx    = tx_q;
  assign done  = done_q;
  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);

endmodule
